// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: BCD digit type, blank pattern and the digit encoder.
package seg7_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit; non-BCD codes show blank.
  function automatic logic [6:0] seg7_encode(input bcd_digit_t d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a
// one-cycle press pulse on the accepted 0->1 transition only.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic btnC,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync0_r;
  logic          sync1_r;
  logic          level_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk) begin
    if (btnC) begin
      sync0_r <= 1'b0;
      sync1_r <= 1'b0;
    end else begin
      sync0_r <= raw;
      sync1_r <= sync0_r;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (btnC) begin
      level_r <= 1'b0;
      press_r <= 1'b0;
      cnt_r   <= '0;
    end else if (sync1_r != level_r) begin
      if (cnt_r == CNT_LAST) begin
        level_r <= sync1_r;
        press_r <= sync1_r;
        cnt_r   <= '0;
      end else begin
        press_r <= 1'b0;
        cnt_r   <= cnt_r + CW'(1);
      end
    end else begin
      press_r <= 1'b0;
      cnt_r   <= '0;
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with debounced buttons, auto-run prescaler and a
// multiplexed common-anode 7-segment display driver.
module bcd_counter_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int TICK_CYCLES     = 100000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REFRESH_CYCLES  = 100000,
  parameter int BLANK_LZ        = 1
) (
  input  logic                    clk,
  input  logic                    btnC,
  input  logic                    btnU,
  input  logic                    btnR,
  input  logic                    btnD,
  input  logic                    btnL,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [4*NUM_DIGITS-1:0] value_bcd
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Button index map: 0 = up, 1 = +10, 2 = down, 3 = auto-run toggle.
  logic [3:0] raw_btn;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] press_ok;

  logic                    run_r;
  logic [PW-1:0]           presc_r;
  logic                    tick;
  logic [4*NUM_DIGITS-1:0] value_r;
  logic [4*NUM_DIGITS-1:0] value_next;
  logic                    step_u;
  logic                    step_r;
  logic                    step_d;
  logic                    step_t;
  logic                    do_inc;
  logic                    inc_ten;
  logic                    carry;
  bcd_digit_t              digit;

  logic [RW-1:0]           refresh_r;
  logic [IW-1:0]           scan_idx_r;
  logic [NUM_DIGITS-1:0]   upper_zero;
  bcd_digit_t              digit_sel;
  logic                    blank;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [6:0]              seg_next;
  logic                    dp_next;
  logic [NUM_DIGITS-1:0]   an_r;
  logic [6:0]              seg_r;
  logic                    dp_r;

  assign raw_btn = {btnL, btnD, btnR, btnU};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .btnC (btnC),
      .raw  (raw_btn[i]),
      .level(btn_level[i]),
      .press(btn_press[i])
    );
  end

  // A press is only honoured while its debounced level is high.
  assign press_ok = btn_press & btn_level;

  // Fixed priority: up > +10 > down > auto-run tick; losers are dropped.
  assign tick    = run_r && (presc_r == PW'(TICK_CYCLES - 1));
  assign step_u  = press_ok[0];
  assign step_r  = !press_ok[0] && press_ok[1];
  assign step_d  = !press_ok[0] && !press_ok[1] && press_ok[2];
  assign step_t  = !(|press_ok[2:0]) && tick;
  assign do_inc  = step_u | step_r | step_t;
  assign inc_ten = step_r;

  // Auto-run flag and prescaler; prescaler idles at zero while stopped.
  always_ff @(posedge clk) begin
    if (btnC) begin
      run_r   <= 1'b0;
      presc_r <= '0;
    end else begin
      run_r <= run_r ^ press_ok[3];
      if (!run_r || tick) begin
        presc_r <= '0;
      end else begin
        presc_r <= presc_r + PW'(1);
      end
    end
  end

  // Digit-wise BCD ripple: carry injected at digit 0 or 1, borrow at digit 0.
  always_comb begin
    value_next = value_r;
    carry      = step_d;
    digit      = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      digit = value_r[4*k +: 4];
      if (do_inc && (k == (inc_ten ? 1 : 0))) begin
        carry = 1'b1;
      end else begin
        carry = carry;
      end
      if (!carry) begin
        value_next[4*k +: 4] = digit;
      end else if (do_inc) begin
        if (digit >= 4'd9) begin
          value_next[4*k +: 4] = 4'd0;
          carry                = 1'b1;
        end else begin
          value_next[4*k +: 4] = digit + 4'd1;
          carry                = 1'b0;
        end
      end else begin
        if (digit == 4'd0) begin
          value_next[4*k +: 4] = 4'd9;
          carry                = 1'b1;
        end else if (digit > 4'd9) begin
          value_next[4*k +: 4] = 4'd9;
          carry                = 1'b0;
        end else begin
          value_next[4*k +: 4] = digit - 4'd1;
          carry                = 1'b0;
        end
      end
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (btnC) begin
      value_r <= '0;
    end else begin
      value_r <= value_next;
    end
  end

  assign value_bcd = value_r;

  // Refresh timer and scan index walking digits 0..NUM_DIGITS-1.
  always_ff @(posedge clk) begin
    if (btnC) begin
      refresh_r  <= '0;
      scan_idx_r <= '0;
    end else if (refresh_r == RW'(REFRESH_CYCLES - 1)) begin
      refresh_r  <= '0;
      scan_idx_r <= (scan_idx_r == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx_r + IW'(1);
    end else begin
      refresh_r  <= refresh_r + RW'(1);
    end
  end

  // upper_zero[k]: digits k..N-1 are all zero (leading-zero run).
  always_comb begin
    upper_zero                 = '0;
    upper_zero[NUM_DIGITS-1]   = (value_r[4*(NUM_DIGITS-1) +: 4] == 4'd0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      upper_zero[k] = upper_zero[k+1] && (value_r[4*k +: 4] == 4'd0);
    end
  end

  // Next display pattern for the selected digit, with leading-zero blanking.
  always_comb begin
    digit_sel = value_r[{scan_idx_r, 2'b00} +: 4];
    blank     = (BLANK_LZ != 0) && (scan_idx_r != '0) && upper_zero[scan_idx_r];
    an_next   = '1;
    seg_next  = SEG_BLANK;
    if (blank) begin
      an_next  = '1;
      seg_next = SEG_BLANK;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (k == int'(scan_idx_r)) begin
          an_next[k] = 1'b0;
        end else begin
          an_next[k] = 1'b1;
        end
      end
      seg_next = seg7_encode(digit_sel);
    end
    dp_next = ~((scan_idx_r == '0) && run_r);
  end

  // Registered pin drivers.
  always_ff @(posedge clk) begin
    if (btnC) begin
      an_r  <= '1;
      seg_r <= SEG_BLANK;
      dp_r  <= 1'b1;
    end else begin
      an_r  <= an_next;
      seg_r <= seg_next;
      dp_r  <= dp_next;
    end
  end

  assign an  = an_r;
  assign seg = seg_r;
  assign dp  = dp_r;

endmodule
